// File: rtl/tt_um_inverter_loop_tester.sv
// tt_um_inverter_loop_tester: square-wave stimulus and round-trip latency capture for a double-inverter tile
// Ports: clk, rst_n (async active-low), ena (ignored),
//   ui_in[0] run, ui_in[1] display select, ui_in[7:2] half-period code P (half period 4*(P+1)),
//   uio_in[1] asynchronous return, uo_out latency (or error count),
//   uio_out {3'b0, done, timeout, busy, 1'b0, stim}, uio_oe constant 8'b0001_1101.
// Optional: define INVTEST_ERRCNT_EN for a saturating timeout counter shown when ui_in[1]=1.
module tt_um_inverter_loop_tester #(
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  typedef enum logic [1:0] {IDLE, TOGGLE, WAIT, HOLD} state_t;
  state_t state, state_n;
  logic run_s1, run_s2, run_s3, ret_s1, ret_s2, stim, tout, done;
  logic start, mism, timed, hold_end;
  logic [7:0] cnt, hp, lat;
  logic [8:0] cnt_inc;
  logic unused;
  always_comb begin
    start = run_s2 & ~run_s3;
    mism = ret_s2 != stim;
    cnt_inc = {1'b0, cnt} + 9'd1;
    timed = mism && cnt_inc >= 9'(TIMEOUT);
    // H-1 = 4*(P+1)-1 = {P, 2'b11}
    hold_end = hp >= {ui_in[7:2], 2'b11};
    state_n = state == IDLE   ? (start ? TOGGLE : IDLE) :
              state == TOGGLE ? WAIT :
              state == WAIT   ? ((!mism || timed) ? HOLD : WAIT) :
                                (hold_end ? (run_s2 ? TOGGLE : IDLE) : HOLD);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      {run_s1, run_s2, run_s3, ret_s1, ret_s2} <= '0;
      {stim, tout, done} <= '0;
      cnt <= 8'd0;
      hp <= 8'd0;
      lat <= 8'd0;
    end else begin
      state <= state_n;
      run_s1 <= ui_in[0];
      run_s2 <= run_s1;
      run_s3 <= run_s2;
      ret_s1 <= uio_in[1];
      ret_s2 <= ret_s1;
      done <= 1'b0;
      if (state_n == TOGGLE) begin
        stim <= ~stim;
        cnt <= 8'd0;
        hp <= 8'd0;
        if (state == IDLE) tout <= 1'b0;
      end else begin
        hp <= hp + {7'd0, hp != 8'hff};
      end
      // the toggle cycle already sees the stale return, so it counts toward latency
      if (state == TOGGLE) cnt <= {7'd0, mism};
      if (state == WAIT) begin
        if (!mism) begin
          lat <= cnt;
          done <= 1'b1;
        end else if (timed) begin
          lat <= 8'hff;
          tout <= 1'b1;
          done <= 1'b1;
        end else begin
          cnt <= cnt_inc[7:0];
        end
      end
    end
  end
`ifdef INVTEST_ERRCNT_EN
  logic [7:0] err;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 8'd0;
    else if (state == WAIT && timed && err != 8'hff) err <= err + 8'd1;
  end
  assign uo_out = ui_in[1] ? err : lat;
  assign unused = ^{ena, uio_in[7:2], uio_in[0]};
`else
  assign uo_out = lat;
  assign unused = ^{ena, uio_in[7:2], uio_in[0], ui_in[1]};
`endif
  assign uio_out = {3'b000, done, tout, state != IDLE, 1'b0, stim};
  assign uio_oe = 8'b0001_1101;
endmodule
